handshake_pipe_flush: RTL

HANDSHAKE_PIPE_FLUSH -- requirements
Module: handshake_pipe_flush

---
 rtl/pipe_pkg.sv | 11 +
 rtl/handshake_pipe_stage.sv | 45 ++++
 rtl/handshake_pipe_flush.sv | 57 +++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: buffering-mode constants and a clog2 helper shared by the pipe modules
package pipe_pkg;
  localparam int FR_HALF = 0;
  localparam int FR_SKID = 1;
  function automatic int clog2(input int x);
    int r;
    r = 0;
    while ((1 << r) < x) r++;
    return r;
  endfunction
endpackage

// File: rtl/handshake_pipe_stage.sv
// handshake_pipe_stage: one valid/ready register stage, either a 2-entry skid or a 1-entry half-rate buffer
module handshake_pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FULL_RATE = FR_SKID
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_data
);
  logic             main_v_q, main_v_d;
  logic [WIDTH-1:0] main_q;
  assign deq_valid = main_v_q;
  assign deq_data  = main_q;
  if (FULL_RATE == FR_SKID) begin : g_skid
    logic             skid_v_q, skid_v_d, enq, slot;
    logic [WIDTH-1:0] skid_q;
    assign enq_ready = !skid_v_q;
    assign enq       = enq_valid && !skid_v_q;
    // main slot is free for a new occupant this cycle
    assign slot      = !main_v_q || deq_ready;
    always_comb begin
      main_v_d = slot ? (skid_v_q || enq) : 1'b1;
      skid_v_d = slot ? 1'b0 : (skid_v_q || enq);
    end
    always_ff @(posedge clk) skid_v_q <= rst_n && !flush && skid_v_d;
    always_ff @(posedge clk) begin
      if (slot && skid_v_q) main_q <= skid_q;
      else if (slot && enq) main_q <= enq_data;
      if (!slot && enq) skid_q <= enq_data;
    end
  end else begin : g_half
    assign enq_ready = !main_v_q;
    always_comb main_v_d = main_v_q ? !deq_ready : enq_valid;
    always_ff @(posedge clk) if (!main_v_q && enq_valid) main_q <= enq_data;
  end
  always_ff @(posedge clk) main_v_q <= rst_n && !flush && main_v_d;
endmodule

// File: rtl/handshake_pipe_flush.sv
// handshake_pipe_flush: chain of valid/ready stages with flush and an occupancy counter
module handshake_pipe_flush
  import pipe_pkg::*;
#(
  parameter int NUM_STAGES = 8,
  parameter int WIDTH      = 32,
  parameter int FULL_RATE  = FR_SKID
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                valid,
  output logic                                ready_pipe,
  input  logic [WIDTH-1:0]                    data,
  output logic                                valid_pipe,
  input  logic                                ready,
  output logic [WIDTH-1:0]                    data_pipe,
  output logic [clog2(2*NUM_STAGES+1)-1:0]    count,
  output logic                                empty
);
  localparam int CW = clog2(2*NUM_STAGES+1);
  logic             v [NUM_STAGES+1];
  logic             r [NUM_STAGES+1];
  logic [WIDTH-1:0] d [NUM_STAGES+1];
  logic             live, up, dn;
  logic [CW-1:0]    count_q, count_d;
  // flush and reset block both sides in the same cycle so no beat slips through
  assign live       = rst_n && !flush;
  assign ready_pipe = live && r[0];
  assign valid_pipe = live && v[NUM_STAGES];
  assign data_pipe  = d[NUM_STAGES];
  assign v[0]       = live && valid;
  assign d[0]       = data;
  assign r[NUM_STAGES] = ready;
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    handshake_pipe_stage #(
      .WIDTH     (WIDTH),
      .FULL_RATE (FULL_RATE)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .enq_valid (v[i]),
      .enq_ready (r[i]),
      .enq_data  (d[i]),
      .deq_valid (v[i+1]),
      .deq_ready (r[i+1]),
      .deq_data  (d[i+1])
    );
  end
  assign up = valid && ready_pipe;
  assign dn = valid_pipe && ready;
  always_comb count_d = (up && !dn) ? count_q + 1'b1 : (dn && !up) ? count_q - 1'b1 : count_q;
  always_ff @(posedge clk) count_q <= live ? count_d : '0;
  assign count = count_q;
  assign empty = count_q == '0;
endmodule
